// File: rtl/path_delay_meter_if.sv
// Handshake and path-under-test signals of the path delay meter.
// The meter itself connects through the slave modport; the driver of start/ret/res_ready uses master.
interface path_delay_meter_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             busy;
    logic             launch;
    logic             ret;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_cycles;
    logic             res_timeout;

    modport slave (
        input  start, ret, res_ready,
        output busy, launch, res_valid, res_cycles, res_timeout
    );

    modport master (
        output start, ret, res_ready,
        input  busy, launch, res_valid, res_cycles, res_timeout
    );
endinterface

// File: rtl/path_delay_meter.sv
// Launches one transition into an external path and counts clock edges until it returns on ret.
// The result, or a timeout after MAX_CYCLES, is offered on a valid/ready handshake.
module path_delay_meter #(
    parameter int MAX_CYCLES  = 255,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    path_delay_meter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic             launch_q;
    logic             busy_q;
    logic             base_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             res_valid_q;
    logic [CNT_W-1:0] res_cycles_q;
    logic             res_timeout_q;
    logic             ret_s;

    // ret is observed through SYNC_STAGES flops; each stage feeds the next.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ret_s = bus.ret;
        end else begin : g_sync
            for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
                logic stage_q;
                logic stage_in;
                if (gi == 0) begin : g_first
                    assign stage_in = bus.ret;
                end else begin : g_next
                    assign stage_in = g_stage[gi-1].stage_q;
                end
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_q <= 1'b0;
                    end else begin
                        stage_q <= stage_in;
                    end
                end
            end
            assign ret_s = g_stage[SYNC_STAGES-1].stage_q;
        end
    endgenerate

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            launch_q      <= 1'b0;
            busy_q        <= 1'b0;
            base_q        <= 1'b0;
            cnt_q         <= '0;
            res_valid_q   <= 1'b0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        launch_q <= ~launch_q;
                        base_q   <= ret_s;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    // Comparing against the captured baseline makes detection polarity-independent.
                    if (ret_s != base_q) begin
                        res_cycles_q  <= cnt_d;
                        res_timeout_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        state_q       <= ST_DONE;
                    end else if (cnt_d == CNT_W'(MAX_CYCLES)) begin
                        res_cycles_q  <= CNT_W'(MAX_CYCLES);
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.launch      = launch_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_cycles  = res_cycles_q;
    assign bus.res_timeout = res_timeout_q;
endmodule
